// File: rtl/tpu_pkg.sv
// Shared types and constants for the ofmap writeback path.
// Lane 0 sits in the MSBs of every packed ofmap row.
package tpu_pkg;

  localparam int WB_PE_SIZE    = 4;
  localparam int WB_DATA_WIDTH = 8;
  localparam int WB_ADDR_WIDTH = 10;
  localparam int WB_ROWS       = 16;
  localparam int WB_BUF_DEPTH  = 4;

  typedef enum logic [1:0] {
    WB_IDLE  = 2'd0,
    WB_RUN   = 2'd1,
    WB_DRAIN = 2'd2,
    WB_DONE  = 2'd3
  } wb_state_e;

  // MSB bit index of a lane inside a packed row
  function automatic int lane_msb(
    input int lane,
    input int dw,
    input int pe
  );
    return (pe - lane) * dw - 1;
  endfunction

endpackage

// File: rtl/wb_row_fifo.sv
// Row buffer between the accumulator stream and the GLB port.
// Pointers carry a wrap bit so full/empty need no separate counter.
module wb_row_fifo
  import tpu_pkg::*;
#(
  parameter int WIDTH = WB_PE_SIZE * WB_DATA_WIDTH,
  parameter int DEPTH = WB_BUF_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop frees the slot the same cycle, so full+pop may push
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ofmap_writeback.sv
// Buffers quantized ofmap rows and writes them to the GLB.
// Build option: OFMAP_RELU_EN clamps negative lanes to 0 on write.
module ofmap_writeback
  import tpu_pkg::*;
#(
  parameter int PE_SIZE        = WB_PE_SIZE,
  parameter int DATA_WIDTH     = WB_DATA_WIDTH,
  parameter int GLB_ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int ROWS_PER_TILE  = WB_ROWS,
  parameter int BUF_DEPTH      = WB_BUF_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_i,
  input  logic [GLB_ADDR_WIDTH-1:0]     base_addr_i,
  input  logic                          ofmap_valid_i,
  input  logic [DATA_WIDTH*PE_SIZE-1:0] ofmap_row_i,
  input  logic                          glb_ready_i,
  output logic                          glb_wren_o,
  output logic [GLB_ADDR_WIDTH-1:0]     glb_addr_o,
  output logic [DATA_WIDTH*PE_SIZE-1:0] glb_wdata_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          overflow_o
);

  localparam int ROW_W = DATA_WIDTH * PE_SIZE;
  localparam int CW    = $clog2(ROWS_PER_TILE + 1);
  localparam logic [CW-1:0] N_ROWS = CW'(ROWS_PER_TILE);
  localparam logic [CW-1:0] N_LAST = CW'(ROWS_PER_TILE - 1);

  wb_state_e state;
  wb_state_e state_nx;

  logic [GLB_ADDR_WIDTH-1:0] base_q;
  logic [CW-1:0]             acc_cnt;
  logic [CW-1:0]             wr_cnt;
  logic                      ovf_q;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      push;
  logic                      pop;
  logic                      active;
  logic                      take_start;
  logic [ROW_W-1:0]          head;

  assign active     = (state == WB_RUN) || (state == WB_DRAIN);
  assign take_start = (state == WB_IDLE) & start_i;

  assign glb_wren_o = active & ~fifo_empty;
  assign pop        = glb_wren_o & glb_ready_i;
  assign push       = (state == WB_RUN) & ofmap_valid_i &
                      (acc_cnt != N_ROWS) & (~fifo_full | pop);

  assign glb_addr_o = base_q + GLB_ADDR_WIDTH'(wr_cnt);
  assign busy_o     = (state != WB_IDLE);
  assign done_o     = (state == WB_DONE);
  assign overflow_o = ovf_q;

  wb_row_fifo #(
    .WIDTH (ROW_W),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (ofmap_row_i),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Leave RUN/DRAIN on the edge that completes the count
  always_comb begin
    state_nx = state;
    unique case (state)
      WB_IDLE:  if (start_i) state_nx = WB_RUN;
      WB_RUN:   if (push && acc_cnt == N_LAST)
                  state_nx = WB_DRAIN;
      WB_DRAIN: if (pop && wr_cnt == N_LAST)
                  state_nx = WB_DONE;
      WB_DONE:  state_nx = WB_IDLE;
      default:  state_nx = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= WB_IDLE;
      base_q  <= '0;
      acc_cnt <= '0;
      wr_cnt  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (take_start) begin
        base_q  <= base_addr_i;
        acc_cnt <= '0;
        wr_cnt  <= '0;
        ovf_q   <= 1'b0;
      end else begin
        if (push) acc_cnt <= acc_cnt + 1'b1;
        if (pop)  wr_cnt  <= wr_cnt + 1'b1;
      end
      // The accumulator never stalls, so any unaccepted row is lost
      if (ofmap_valid_i && !push) ovf_q <= 1'b1;
    end
  end

`ifdef OFMAP_RELU_EN
  for (genvar i = 0; i < PE_SIZE; i++) begin : g_relu
    localparam int MSB = lane_msb(i, DATA_WIDTH, PE_SIZE);
    assign glb_wdata_o[MSB -: DATA_WIDTH] =
      head[MSB] ? '0 : head[MSB -: DATA_WIDTH];
  end
`else
  assign glb_wdata_o = head;
`endif

endmodule

// File: tb/tb_ofmap_writeback.sv
// Directed + randomized bench for ofmap_writeback with a
// queue-based reference model of the tile write-back behaviour.
module tb_ofmap_writeback;

  localparam int ROWS  = 16;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [9:0]  base_addr_i;
  logic        ofmap_valid_i;
  logic [31:0] ofmap_row_i;
  logic        glb_ready_i;
  logic        glb_wren_o;
  logic [9:0]  glb_addr_o;
  logic [31:0] glb_wdata_o;
  logic        busy_o;
  logic        done_o;
  logic        overflow_o;

  int vectors = 0;
  int miscompares = 0;

  // reference model: phase 0 idle, 1 run, 2 drain, 3 done
  int          m_phase;
  logic [9:0]  m_base;
  int          m_acc;
  int          m_wr;
  logic        m_ovf;
  logic [31:0] mq[$];
  logic [31:0] relu_exp;

  ofmap_writeback dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .base_addr_i   (base_addr_i),
    .ofmap_valid_i (ofmap_valid_i),
    .ofmap_row_i   (ofmap_row_i),
    .glb_ready_i   (glb_ready_i),
    .glb_wren_o    (glb_wren_o),
    .glb_addr_o    (glb_addr_o),
    .glb_wdata_o   (glb_wdata_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .overflow_o    (overflow_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_data(input logic [31:0] r);
    logic [31:0] o;
    o = r;
`ifdef OFMAP_RELU_EN
    for (int i = 0; i < 4; i++) begin
      if (o[8*i+7]) o[8*i +: 8] = 8'h00;
    end
`endif
    return o;
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_base  = '0;
    m_acc   = 0;
    m_wr    = 0;
    m_ovf   = 1'b0;
    mq.delete();
  endtask

  task automatic chk_zero();
    chk("rst_wren", 32'(glb_wren_o), 32'd0);
    chk("rst_addr", 32'(glb_addr_o), 32'd0);
    chk("rst_wdata", glb_wdata_o, 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_ovf", 32'(overflow_o), 32'd0);
  endtask

  task automatic chk_outputs();
    logic        ew;
    logic [9:0]  ea;
    ew = (m_phase == 1 || m_phase == 2) && mq.size() > 0;
    ea = 10'(m_base + 10'(m_wr));
    chk("wren", 32'(glb_wren_o), 32'(ew));
    chk("addr", 32'(glb_addr_o), 32'(ea));
    if (ew) chk("wdata", glb_wdata_o, exp_data(mq[0]));
    chk("busy", 32'(busy_o), 32'(m_phase != 0));
    chk("done", 32'(done_o), 32'(m_phase == 3));
    chk("ovf", 32'(overflow_o), 32'(m_ovf));
  endtask

  task automatic model_edge(
    input logic        v,
    input logic [31:0] row,
    input logic        rdy,
    input logic        st,
    input logic [9:0]  b
  );
    int ph;
    bit ew;
    bit pop;
    bit push;
    ph   = m_phase;
    ew   = (ph == 1 || ph == 2) && mq.size() > 0;
    pop  = ew && rdy;
    push = (ph == 1) && v && (mq.size() < DEPTH || pop);
    if (ph == 0 && st) begin
      m_base = b;
      m_acc  = 0;
      m_wr   = 0;
      m_ovf  = 1'b0;
    end
    if (v && !push) m_ovf = 1'b1;
    if (pop) begin
      void'(mq.pop_front());
      m_wr++;
    end
    if (push) begin
      mq.push_back(row);
      m_acc++;
    end
    case (ph)
      0: if (st) m_phase = 1;
      1: if (m_acc == ROWS) m_phase = 2;
      2: if (m_wr == ROWS) m_phase = 3;
      default: m_phase = 0;
    endcase
  endtask

  // One clock: drive at negedge, check, advance model, next negedge
  task automatic step(
    input logic        v,
    input logic [31:0] row,
    input logic        rdy,
    input logic        st,
    input logic [9:0]  b
  );
    ofmap_valid_i = v;
    ofmap_row_i   = row;
    glb_ready_i   = rdy;
    start_i       = st;
    base_addr_i   = b;
    #1;
    chk_outputs();
    model_edge(v, row, rdy, st, b);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic finish_tile();
    for (int n = 0; n < 80 && m_phase != 0; n++) begin
      step(m_phase == 1, $urandom, 1'b1, 1'b0, 10'd0);
    end
    chk("tile_end_idle", 32'(busy_o), 32'd0);
  endtask

  initial begin
`ifdef OFMAP_RELU_EN
    relu_exp = 32'h007F0001;
`else
    relu_exp = 32'h807FFF01;
`endif
    rst = 1'b1;
    start_i = 1'b0;
    base_addr_i = '0;
    ofmap_valid_i = 1'b0;
    ofmap_row_i = '0;
    glb_ready_i = 1'b0;
    model_reset();
    @(negedge clk);
    chk_zero();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 1: streaming tile, 16 back-to-back rows
    step(0, 0, 1, 1, 10'h100);
    for (int i = 0; i < ROWS; i++) step(1, $urandom, 1, 0, 0);
    finish_tile();

    // 2: stall 6 cycles while 5 rows arrive
    step(0, 0, 1, 1, 10'(($urandom % 512)));
    for (int i = 0; i < 5; i++) step(1, $urandom, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("bp_ovf", 32'(overflow_o), 32'd1);
    finish_tile();

    // 3: full buffer, valid with a pop the same cycle
    step(0, 0, 1, 1, 10'h040);
    for (int i = 0; i < 4; i++) step(1, $urandom, 0, 0, 0);
    step(1, $urandom, 1, 0, 0);
    chk("fullpop_ovf", 32'(overflow_o), 32'd0);
    finish_tile();

    // 4+6: address wrap, first row exercises the clamp
    step(0, 0, 1, 1, 10'h3FE);
    step(1, 32'h807FFF01, 1, 0, 0);
    chk("relu_row", glb_wdata_o, relu_exp);
    chk("wrap_addr0", 32'(glb_addr_o), 32'h3FE);
    for (int i = 0; i < ROWS - 1; i++) step(1, $urandom, 1, 0, 0);
    finish_tile();

    // 5: asynchronous reset after 7 rows, then a clean tile
    step(0, 0, 1, 1, 10'h2A0);
    for (int i = 0; i < 7; i++) step(1, $urandom, 1, 0, 0);
    #2 rst = 1'b1;
    #1 chk_zero();
    model_reset();
    ofmap_valid_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step(0, 0, 1, 1, 10'h155);
    for (int i = 0; i < ROWS; i++) step(1, $urandom, 1, 0, 0);
    finish_tile();

    // random traffic, random starts and bases
    for (int n = 0; n < 1500; n++) begin
      logic st;
      st = ($urandom % 8) == 0;
      step(st ? 1'b0 : 1'($urandom % 4 != 0),
           $urandom,
           1'($urandom % 3 != 0),
           st,
           10'($urandom));
    end
    finish_tile();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
